// File: rtl/jk_ff_bank_pkg.sv
// Shared definitions for the multi-channel JK/D/T/SR flip-flop bank.
package jk_ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_D  = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  localparam int unsigned CNT_W_DEFAULT = 16;

  // All-ones value of a w-bit counter, i.e. where the change counter stops.
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// One channel of next-state logic: no storage, just the mode rules.
module jk_ff_cell
  import jk_ff_bank_pkg::*;
(
  input  mode_e mode,
  input  logic  en,
  input  logic  j,
  input  logic  k,
  input  logic  q,
  output logic  q_next,
  output logic  conflict
);

  // Next state per mode; a disabled channel holds and never flags a conflict.
  always_comb begin
    q_next   = q;
    conflict = 1'b0;
    if (en) begin
      unique case (mode)
        MODE_JK: begin
          if (j && k)   q_next = ~q;
          else if (j)   q_next = 1'b1;
          else if (k)   q_next = 1'b0;
        end
        MODE_D:  q_next = j;
        MODE_T:  if (j) q_next = ~q;
        MODE_SR: begin
          if (j && k)   conflict = 1'b1;
          else if (j)   q_next = 1'b1;
          else if (k)   q_next = 1'b0;
        end
        default: q_next = q;
      endcase
    end
  end

endmodule

// File: rtl/jk_ff_bank.sv
// WIDTH-channel flip-flop bank with clear/load priority, change pulses,
// sticky SR-conflict flags and a saturating change-event counter.
module jk_ff_bank
  import jk_ff_bank_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = CNT_W_DEFAULT
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic [1:0]       _mode,
  input  logic             _E,
  input  logic [WIDTH-1:0] _M,
  input  logic [WIDTH-1:0] _J,
  input  logic [WIDTH-1:0] _K,
  input  logic             _clear,
  input  logic             _load,
  input  logic [WIDTH-1:0] _D,
  input  logic             _err_clr,
  output logic [WIDTH-1:0] _Q,
  output logic [WIDTH-1:0] _QNOT,
  output logic [WIDTH-1:0] _changed,
  output logic [WIDTH-1:0] _err,
  output logic [CNT_W-1:0] _count
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic [WIDTH-1:0] err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] cell_next, cell_conf;
  mode_e            mode_s;

  assign mode_s = mode_e'(_mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_ff_cell u_cell (
      .mode     (mode_s),
      .en       (_E & _M[i]),
      .j        (_J[i]),
      .k        (_K[i]),
      .q        (q_q[i]),
      .q_next   (cell_next[i]),
      .conflict (cell_conf[i])
    );
  end

  // Clear beats load beats per-channel mode logic; conflicts only count when
  // the mode logic is actually in control, and a fresh conflict beats err_clr.
  always_comb begin
    q_d       = cell_next;
    err_d     = _err_clr ? '0 : err_q;
    count_d   = count_q;
    if (_clear) begin
      q_d = RESET_VAL;
    end else if (_load) begin
      q_d = _D;
    end else begin
      err_d = err_d | cell_conf;
    end
    changed_d = q_d ^ q_q;
    if (_clear) begin
      count_d = '0;
    end else if ((|changed_d) && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // All state registers; reset clears everything asynchronously.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      q_q       <= RESET_VAL;
      changed_q <= '0;
      err_q     <= '0;
      count_q   <= '0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  assign _Q       = q_q;
  assign _QNOT    = ~q_q;
  assign _changed = changed_q;
  assign _err     = err_q;
  assign _count   = count_q;

endmodule

// File: doc/jk_ff_bank.md
Name: jk_ff_bank

Overview:
- Parametrised, multi-channel successor to the single JK flip-flop cell in the stdlib.
- WIDTH independent channels share one clock, one runtime-selectable mode (JK / D / T / SR), and a global enable gated by a per-channel mask.
- Adds synchronous clear, parallel load, a per-channel change pulse, a sticky SR-conflict error and a saturating change-event counter.
- Used as a general state/flag register in stdlib-built designs.

Parameters:
- WIDTH, 8, number of channels.
- RESET_VAL, {WIDTH{1'b0}}, value of _Q after reset or _clear.
- CNT_W, 16, width of the change-event counter.

Ports:
- _clock  input  1  rising-edge clock.
- _reset  input  1  asynchronous, active-low reset.
- _mode  input  2  00 JK, 01 D, 10 T, 11 SR.
- _E  input  1  global enable.
- _M  input  WIDTH  per-channel enable mask; channel i is enabled when _E & _M[i].
- _J  input  WIDTH  per-channel J / D / T / S input.
- _K  input  WIDTH  per-channel K / R input; ignored in D and T modes.
- _clear  input  1  synchronous clear.
- _load  input  1  synchronous parallel load.
- _D  input  WIDTH  parallel load data.
- _err_clr  input  1  clears the sticky error.
- _Q  output  WIDTH  registered state.
- _QNOT  output  WIDTH  always ~_Q.
- _changed  output  WIDTH  registered per-channel change flags.
- _err  output  WIDTH  sticky SR-conflict flags.
- _count  output  CNT_W  saturating change-event counter.

Behaviour:
- Reset (_reset=0, asynchronous, highest priority):
  - _Q=RESET_VAL, _QNOT=~RESET_VAL.
  - _changed=0, _err=0, _count=0.
  - Release of reset is honoured at the next rising edge.
- Q update priority per rising edge: _clear > _load > enabled-channel mode logic > hold.
  - _clear: Q<=RESET_VAL for all channels; mask and mode ignored.
  - _load (no _clear): Q<=_D for all channels; mask and mode ignored.
  - Otherwise, an enabled channel i updates per _mode; a disabled channel holds.
- Mode logic for enabled channel i:
  - JK: J&K toggles; J only sets; K only resets; neither holds.
  - D: Q[i]<=J[i].
  - T: J[i]=1 toggles; J[i]=0 holds.
  - SR: S only sets; R only resets; S&R holds Q and sets _err[i]; neither holds.
- _mode is sampled every edge and may change cycle-to-cycle; there is no mode state.
- _QNOT is combinational from the Q register, so it always equals ~_Q, including during reset.
- _changed: at each edge, _changed <= Q_next ^ Q_current.
  - Updated at the same edge as _Q, so it is valid in the same cycle _Q shows the new value.
  - Each change gives a one-cycle pulse; _clear and _load changes count.
- _err:
  - Bit i is set on an SR conflict. The conflict only counts when the channel is enabled and neither _clear nor _load is active.
  - _err_clr zeroes all bits.
  - A new conflict in the same cycle as _err_clr wins, so that bit reads 1 afterwards.
  - _clear does not affect _err.
- _count:
  - Increments by 1 on each edge where (Q_next ^ Q_current) != 0.
  - Saturates at 2^CNT_W-1.
  - _clear sets it to 0. The change caused by that clear is not counted.
- Boundary cases:
  - All mask bits 0 with _E=1: full hold, _changed=0.
  - _load with _D==Q: no change, counter unchanged.
  - Reset asserted mid-operation overrides everything immediately; no partial state is retained.
- No latency beyond one edge; all outputs are registered except _QNOT.

Decomposition:
- Package jk_ff_bank_pkg:
  - Mode encodings MODE_JK=2'b00, MODE_D=2'b01, MODE_T=2'b10, MODE_SR=2'b11.
  - Helper constant for counter saturation.
- Sub-module jk_ff_cell:
  - One-channel combinational next-state and conflict logic.
  - Inputs: mode, en, j, k, q. Outputs: q_next, conflict.
  - Instantiated WIDTH times via generate.
- Top-level holds all registers: Q, changed, err and count, plus the clear/load priority.

Test Plan:
- Reset and JK mode: WIDTH=8, hold _reset=0 → _Q=00, _QNOT=FF. Release; mode JK, _E=1, _M=FF, J=0F, K=F0 → _Q=0F, _changed=0F, _count=1. Next edge J=FF, K=FF → _Q=F0, _changed=FF, _count=2.
- Mask and enable: _Q=00, mode T, J=FF, _M=AA, _E=1 → _Q=AA. Next edge with _E=0 → _Q=AA, _changed=00, _count unchanged.
- SR conflict: mode SR, _Q=00, J=03, K=01 → _Q=02, _err=01. Next edge with _err_clr=1 and J=K=01 → _err=01 (set wins). Next edge with _err_clr=1 and J=K=0 → _err=00.
- Priority: _clear=1, _load=1, _D=5A, J=FF (mode D), _count=7 → _Q=RESET_VAL (00), _count=0. Next edge with _load=1 only → _Q=5A, _count=1. Next edge load 5A again → _changed=00, _count=1.
- Saturation: CNT_W=2, mode T, J=01, enabled every edge for 5 edges → _count reads 1, 2, 3, 3, 3.
- Asynchronous reset mid-operation: assert _reset=0 between edges while _Q=5A and _err=01 → immediately _Q=00, _err=00, _changed=00, _count=0 without any clock edge.
